// File: rtl/vc_pop_arbiter.sv
// Round-robin arbiter that drains four virtual-channel FIFOs into one downstream FIFO.
// Ownership is held for up to QUANTUM consecutive pops; the popped word is pushed one cycle later.
module vc_pop_arbiter #(
   parameter int DATA_WIDTH = 6,
   parameter int QUANTUM    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    pause,
   input  logic [3:0]              empty,
   input  logic [4*DATA_WIDTH-1:0] data_in,
   input  logic                    dest_almost_full,
   input  logic                    dest_full,
   output logic [3:0]              pop,
   output logic                    push,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic [1:0]              grant,
   output logic                    active,
   output logic                    err_overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam logic [3:0] QUANT = 4'(QUANTUM);

   state_t                state;
   state_t                state_nxt;
   logic [1:0]            owner;
   logic [1:0]            owner_nxt;
   logic [3:0]            burst_cnt;
   logic [3:0]            burst_nxt;
   logic [1:0]            src_p1;
   logic [DATA_WIDTH-1:0] last_p1;
   logic [3:0]            req;
   logic                  stall_req;
   logic                  arb_en;
   logic                  hold;
   logic                  hit_vld;
   logic [1:0]            hit_idx;
   logic [1:0]            cand;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v >= QUANT) ? QUANT : v + 4'd1;
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++)
         if (oh[i]) idx = 2'(i);
      return idx;
   endfunction

   assign req       = ~empty;
   assign stall_req = pause | dest_almost_full;
   assign arb_en    = (state == RUN) && enable && !stall_req;
   // burst_cnt==0 means nobody owns the channel yet, so owner=3 after reset hands VC0 first pick
   assign hold      = req[owner] && (burst_cnt != 4'd0) && (burst_cnt < QUANT);
   assign grant     = owner;

   always_comb begin
      hit_vld = 1'b0;
      hit_idx = owner;
      cand    = owner;
      for (int k = 1; k <= 4; k++) begin
         cand = owner + 2'(k);
         if (!hit_vld && req[cand]) begin
            hit_vld = 1'b1;
            hit_idx = cand;
         end
      end
   end

   always_comb begin
      pop       = 4'd0;
      owner_nxt = owner;
      burst_nxt = burst_cnt;
      if (arb_en) begin
         if (hold) begin
            pop[owner] = 1'b1;
            burst_nxt  = sat_inc(burst_cnt);
         end else if (hit_vld) begin
            pop[hit_idx] = 1'b1;
            owner_nxt    = hit_idx;
            burst_nxt    = 4'd1;
         end else begin
            burst_nxt = 4'd0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = RUN;
         RUN:     if (!enable) state_nxt = IDLE;
                  else if (stall_req) state_nxt = STALL;
         STALL:   if (!enable) state_nxt = IDLE;
                  else if (!stall_req) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   assign data_out = push ? data_in[int'(src_p1)*DATA_WIDTH +: DATA_WIDTH] : last_p1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         active       <= 1'b0;
         owner        <= 2'd3;
         burst_cnt    <= 4'd0;
         push         <= 1'b0;
         src_p1       <= 2'd0;
         last_p1      <= '0;
         err_overflow <= 1'b0;
      end else begin
         state        <= state_nxt;
         active       <= (state_nxt == RUN);
         owner        <= owner_nxt;
         burst_cnt    <= burst_nxt;
         err_overflow <= err_overflow | (push & dest_full);
         // pop -> push stage: FIFO read data arrives alongside push
         push         <= |pop;
         if (|pop) src_p1 <= onehot_idx(pop);
         if (push) last_p1 <= data_out;
      end
   end

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter with a small behavioural model of the four source FIFOs.
module tb_vc_pop_arbiter;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b0;
   logic         pause = 1'b0;
   logic         dest_almost_full = 1'b0;
   logic         dest_full = 1'b0;
   logic [3:0]   empty;
   logic [4*W-1:0] data_in;
   logic [3:0]   pop;
   logic         push;
   logic [W-1:0] data_out;
   logic [1:0]   grant;
   logic         active;
   logic         err_overflow;

   logic [W-1:0] mem [4][64];
   logic [W-1:0] rdata [4];
   int           wr [4];
   int           rd [4];
   logic         flush = 1'b0;

   int total = 0;
   int bad   = 0;

   vc_pop_arbiter #(.DATA_WIDTH(W), .QUANTUM(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pause(pause), .empty(empty),
      .data_in(data_in), .dest_almost_full(dest_almost_full), .dest_full(dest_full),
      .pop(pop), .push(push), .data_out(data_out), .grant(grant), .active(active),
      .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   // Source FIFO model: one-cycle read latency, read data valid in the cycle after pop
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (flush) rd[i] <= wr[i];
         else if (pop[i] && rd[i] != wr[i]) begin
            rdata[i] <= mem[i][rd[i] % 64];
            rd[i]    <= rd[i] + 1;
         end
      end
   end

   always_comb begin
      empty   = 4'hF;
      data_in = '0;
      for (int i = 0; i < 4; i++) begin
         empty[i] = (rd[i] == wr[i]);
         data_in[i*W +: W] = rdata[i];
      end
   end

   function automatic logic [W-1:0] word(input int vc, input int k);
      return {2'(vc), 4'(k)};
   endfunction

   task automatic load(input int vc, input int n);
      for (int k = 0; k < n; k++) begin
         mem[vc][wr[vc] % 64] = word(vc, k);
         wr[vc] = wr[vc] + 1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      enable = 1'b0; pause = 1'b0; dest_almost_full = 1'b0; dest_full = 1'b0;
      reset = 1'b0; flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0; reset = 1'b1;
   endtask

   task automatic start_run();
      enable = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (pop !== 4'd0) begin bad++; $display("FAIL rst_pop got=%b want=0000", pop); end
      total++; if (push !== 1'b0) begin bad++; $display("FAIL rst_push got=%b want=0", push); end
      total++; if (data_out !== 6'd0) begin bad++; $display("FAIL rst_data got=%h want=00", data_out); end
      total++; if (grant !== 2'd3) begin bad++; $display("FAIL rst_grant got=%0d want=3", grant); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_active got=%b want=0", active); end
      total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_overflow); end
   endtask

   task automatic test_single_vc();
      logic [3:0]   exp_pop [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
      logic         exp_push [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [1:0]   exp_grant [5] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
      logic [W-1:0] exp_data [5] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h02};
      do_reset();
      load(0, 3);
      start_run();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         total++; if (pop !== exp_pop[c]) begin bad++; $display("FAIL single_pop c=%0d got=%b want=%b", c, pop, exp_pop[c]); end
         total++; if (push !== exp_push[c]) begin bad++; $display("FAIL single_push c=%0d got=%b want=%b", c, push, exp_push[c]); end
         total++; if (grant !== exp_grant[c]) begin bad++; $display("FAIL single_grant c=%0d got=%0d want=%0d", c, grant, exp_grant[c]); end
         if (c >= 1) begin
            total++; if (data_out !== exp_data[c]) begin bad++; $display("FAIL single_data c=%0d got=%h want=%h", c, data_out, exp_data[c]); end
         end
      end
   endtask

   task automatic test_rotation();
      logic [3:0]   ep;
      logic [W-1:0] ed;
      logic [1:0]   eg;
      do_reset();
      for (int v = 0; v < 4; v++) load(v, 10);
      start_run();
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk); #1;
         ep = 4'b0001 << ((k / 4) % 4);
         total++; if (pop !== ep) begin bad++; $display("FAIL rot_pop k=%0d got=%b want=%b", k, pop, ep); end
         if (k >= 1) begin
            ed = word(((k - 1) / 4) % 4, ((k - 1) / 16) * 4 + (k - 1) % 4);
            eg = 2'(((k - 1) / 4) % 4);
            total++; if (push !== 1'b1) begin bad++; $display("FAIL rot_push k=%0d got=%b want=1", k, push); end
            total++; if (data_out !== ed) begin bad++; $display("FAIL rot_data k=%0d got=%h want=%h", k, data_out, ed); end
            total++; if (grant !== eg) begin bad++; $display("FAIL rot_grant k=%0d got=%0d want=%0d", k, grant, eg); end
         end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] ep;
      do_reset();
      load(1, 6);
      start_run();
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk); #1;
         ep = (c < 6) ? 4'b0010 : 4'b0000;
         total++; if (pop !== ep) begin bad++; $display("FAIL wrap_pop c=%0d got=%b want=%b", c, pop, ep); end
         if (c >= 1) begin
            total++; if (grant !== 2'd1) begin bad++; $display("FAIL wrap_grant c=%0d got=%0d want=1", c, grant); end
         end
      end
   endtask

   task automatic test_pause();
      logic [3:0]   exp_pop [9]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
      logic         exp_push [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic         exp_act [9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [W-1:0] exp_data [9] = '{6'h00, 6'h20, 6'h21, 6'h21, 6'h21, 6'h21, 6'h22, 6'h23, 6'h30};
      do_reset();
      load(2, 8);
      load(3, 4);
      start_run();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c == 2) pause = 1'b1;
         #1;
         total++; if (pop !== exp_pop[c]) begin bad++; $display("FAIL pause_pop c=%0d got=%b want=%b", c, pop, exp_pop[c]); end
         total++; if (push !== exp_push[c]) begin bad++; $display("FAIL pause_push c=%0d got=%b want=%b", c, push, exp_push[c]); end
         total++; if (active !== exp_act[c]) begin bad++; $display("FAIL pause_active c=%0d got=%b want=%b", c, active, exp_act[c]); end
         if (c >= 1) begin
            total++; if (data_out !== exp_data[c]) begin bad++; $display("FAIL pause_data c=%0d got=%h want=%h", c, data_out, exp_data[c]); end
         end
         if (c == 4) pause = 1'b0;
      end
   endtask

   task automatic test_overflow();
      do_reset();
      load(0, 6);
      start_run();
      @(negedge clk); @(negedge clk);
      @(negedge clk);
      dest_almost_full = 1'b1; dest_full = 1'b1;
      #1;
      total++; if (pop !== 4'd0) begin bad++; $display("FAIL ovf_pop got=%b want=0000", pop); end
      total++; if (push !== 1'b1) begin bad++; $display("FAIL ovf_push got=%b want=1", push); end
      total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_err_early got=%b want=0", err_overflow); end
      @(negedge clk);
      dest_full = 1'b0;
      #1;
      total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_err_set got=%b want=1", err_overflow); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL ovf_active got=%b want=0", active); end
      total++; if (pop !== 4'd0) begin bad++; $display("FAIL ovf_pop_stall got=%b want=0000", pop); end
      dest_almost_full = 1'b0;
      @(negedge clk); #1;
      total++; if (pop !== 4'b0001) begin bad++; $display("FAIL ovf_resume_pop got=%b want=0001", pop); end
      @(negedge clk); #1;
      total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_err_sticky got=%b want=1", err_overflow); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_err_clear got=%b want=0", err_overflow); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int v = 0; v < 4; v++) load(v, 10);
      start_run();
      for (int c = 0; c < 6; c++) @(negedge clk);
      #1;
      total++; if (pop !== 4'b0010) begin bad++; $display("FAIL ares_pre_pop got=%b want=0010", pop); end
      total++; if (push !== 1'b1) begin bad++; $display("FAIL ares_pre_push got=%b want=1", push); end
      #2 reset = 1'b0;
      #1;
      total++; if (pop !== 4'd0) begin bad++; $display("FAIL ares_pop got=%b want=0000", pop); end
      total++; if (push !== 1'b0) begin bad++; $display("FAIL ares_push got=%b want=0", push); end
      total++; if (data_out !== 6'd0) begin bad++; $display("FAIL ares_data got=%h want=00", data_out); end
      total++; if (grant !== 2'd3) begin bad++; $display("FAIL ares_grant got=%0d want=3", grant); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL ares_active got=%b want=0", active); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      total++; if (pop !== 4'b0001) begin bad++; $display("FAIL ares_first_pop got=%b want=0001", pop); end
      @(negedge clk); #1;
      total++; if (grant !== 2'd0) begin bad++; $display("FAIL ares_first_grant got=%0d want=0", grant); end
      total++; if (data_out !== word(0, 4)) begin bad++; $display("FAIL ares_first_data got=%h want=%h", data_out, word(0, 4)); end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         wr[i] = 0;
         rd[i] = 0;
         rdata[i] = '0;
      end
      test_reset();
      test_single_vc();
      test_rotation();
      test_wrap();
      test_pause();
      test_overflow();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
